// File: rtl/mem3_result_streamer.sv
// rtl/mem3_result_streamer.sv - streams a run of mem3 result words onto a valid/ready output
//
// Purpose: on a start pulse, reads word_count words from mem3 starting at base_addr
// (addresses wrap modulo MEM_SIZE; 1-cycle read latency). The words are buffered
// in a 2-entry FIFO and presented on a valid/ready stream, with out_last marking
// the final word. done pulses for one cycle when the run has fully drained.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_drain     1-cycle start pulse, honoured only when idle
//   base_addr       first mem3 address (sampled with start_drain)
//   word_count      number of words, 0..MEM_SIZE (sampled with start_drain)
//   read_en         mem3 read enable
//   read_address    mem3 read address
//   mem_data        mem3 read data, valid the cycle after read_en
//   out_valid       out_data/out_last hold a word
//   out_ready       consumer accepts the word when out_valid is high
//   out_data        streamed word
//   out_last        final word of the run
//   busy            run in progress
//   done            1-cycle end-of-run pulse
module mem3_result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_drain,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [2:0]            FIFO_CAP  = 3'(FIFO_DEPTH);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic [1:0]            w_count_next;
  logic                  w_final_read;

  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo_data[r_rd_ptr];
  assign out_last     = r_fifo_last[r_rd_ptr];
  assign read_address = r_addr;

  // A read in flight always lands in the FIFO on the next edge, so it counts
  // against capacity; a word leaving this cycle frees its slot immediately.
  assign w_push       = r_inflight;
  assign w_pop        = out_valid & out_ready;
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_final_read = read_en && (r_remaining == CNT_ONE);

  always_comb begin
    w_state_next = r_state;
    read_en      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_drain) begin
          w_state_next = (word_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        read_en = (r_remaining != '0) && (w_occ < FIFO_CAP);
        if (read_en && (r_remaining == CNT_ONE)) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        // No reads are issued here, so an empty FIFO next cycle also means
        // nothing is left in flight.
        if (w_count_next == 2'd0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && start_drain) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
      end else if (read_en) begin
        r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_ONE;
        r_remaining <= r_remaining - CNT_ONE;
      end
      r_inflight      <= read_en;
      r_inflight_last <= w_final_read;
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

endmodule
